shiftadd_multiplier_system: RTL and testbench
=============================================

Name: shiftadd_multiplier_system

Overview:
- Parametrised successor to the fixed x2 datapath: multiplies two DATAWIDTH-bit unsigned operands with a sequential shift-add algorithm.
- Controlled by an internal FSM with a start/busy/done handshake.
- Sits beside the register bank / ALU datapath as a multi-cycle arithmetic unit.
- The product is held on the output until the next accepted start.

Parameters:
- DATAWIDTH, 8, operand width W (>=2); product is 2W bits.
- CNTWIDTH, $clog2(DATAWIDTH+1), width of iteration counter.

Ports:
- Clk_System  in  1  system clock, rising edge.
- lowRst_System  in  1  asynchronous active-low reset.
- sStart  in  1  request; sampled only in IDLE.
- sDataInA  in  W  multiplicand; captured on accepted start.
- sDataInB  in  W  multiplier; captured on accepted start.
- sProduct  out  2W  result register.
- sBusy  out  1  high from LOAD through CALC.
- sDone  out  1  one-cycle pulse when sProduct becomes valid.
- sZero  out  1  product == 0, registered with sProduct.
- sOverflow  out  1  upper W bits of product nonzero, i.e. result does not fit in W bits.

Behaviour:
- Reset (async, lowRst_System=0):
  - state=IDLE; sProduct=0, sBusy=0, sDone=0, sZero=0, sOverflow=0; internal regs cleared.
  - Reset mid-operation aborts immediately; no sDone is produced.
- States: IDLE, LOAD, CALC, DONE.
- IDLE:
  - sStart=1 -> LOAD, capturing A and B into internal regs.
  - sStart=0 -> stay in IDLE.
- LOAD (1 cycle):
  - acc (W+1 bits) = 0; P = {acc[W-1:0], Breg}; counter = W.
  - sBusy=1. -> CALC.
- CALC (exactly W cycles):
  - Each cycle: sum = acc + (P[0] ? Areg : 0), W+1 bits with carry kept.
  - Then {acc,P} shift right by 1 with the carry entering the MSB; counter decrements.
  - When counter reaches 1 in CALC -> DONE.
- DONE (1 cycle):
  - sProduct <= concatenated 2W result; sZero, sOverflow updated.
  - sDone=1, sBusy=0. -> IDLE.
- Latency: start seen in cycle 0 -> sDone in cycle W+2. Back-to-back start accepted in the cycle after DONE.
- sStart during LOAD/CALC/DONE is ignored (not queued). Operands may change freely after acceptance.
- sProduct and flags hold their value in IDLE/LOAD/CALC until the next DONE.
- No overflow beyond 2W bits is possible: max (2^W-1)^2 < 2^2W.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - CALC -> DONE as soon as the remaining multiplier bits are all zero (including B=0 at LOAD, giving 0 CALC cycles, i.e. LOAD -> DONE directly).
  - Latency varies: 2 + (index of highest set bit of B + 1) cycles.
  - Result is identical to full iteration.
- Undefined: fixed W CALC cycles always.

Decomposition:
- Package mult_pkg:
  - state enum typedef (IDLE, LOAD, CALC, DONE).
  - localparam state encoding.
  - function for counter width.
- Sub-module mult_addshift_step (combinational): inputs acc, P, Areg; outputs next acc/P. Instantiated once by the FSM module.

Test Plan:
- W=8, A=0x57 (87), B=0x02, start pulse -> sDone at cycle 10, sProduct=0x00AE, sZero=0, sOverflow=0.
- A=0xFF, B=0xFF -> sProduct=0xFE01, sOverflow=1; sBusy high cycles 1..9.
- A=0x00, B=0x9C -> sProduct=0x0000, sZero=1.
- With MULT_EARLY_EXIT_EN, B=0x00 -> sDone at cycle 2. B=0x03, A=0x10 -> sProduct=0x0030, sDone at cycle 4.
- Start held high through an operation, operands changed mid-CALC -> exactly one result per accepted start; second start accepted cycle W+3; results match captured operands.
- Reset asserted during CALC cycle 5 -> outputs 0 immediately, no sDone. After release, new start A=0x0C, B=0x0B -> sProduct=0x0084.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: FSM encoding and counter sizing shared by the shift-add multiplier
package mult_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/mult_addshift_step.sv
// mult_addshift_step: one add-then-shift iteration of the {acc,P} product register
module mult_addshift_step #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH:0]   acc_i,
    input  logic [DATAWIDTH-1:0] p_i,
    input  logic [DATAWIDTH-1:0] a_i,
    output logic [DATAWIDTH:0]   acc_o,
    output logic [DATAWIDTH-1:0] p_o
);
    logic [DATAWIDTH:0] sum;
    always_comb begin
        sum   = acc_i + (p_i[0] ? {1'b0, a_i} : '0);
        acc_o = {1'b0, sum[DATAWIDTH:1]};
        p_o   = {sum[0], p_i[DATAWIDTH-1:1]};
    end
endmodule

// File: rtl/shiftadd_multiplier_system.sv
// shiftadd_multiplier_system: sequential shift-add multiplier; MULT_EARLY_EXIT_EN stops once remaining multiplier bits are zero
module shiftadd_multiplier_system
    import mult_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = cnt_width(DATAWIDTH)
) (
    input  logic                     Clk_System,
    input  logic                     lowRst_System,
    input  logic                     sStart,
    input  logic [DATAWIDTH-1:0]     sDataInA,
    input  logic [DATAWIDTH-1:0]     sDataInB,
    output logic [2*DATAWIDTH-1:0]   sProduct,
    output logic                     sBusy,
    output logic                     sDone,
    output logic                     sZero,
    output logic                     sOverflow
);
    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   a_q, a_d, p_q, p_d, p_s;
    logic [DATAWIDTH:0]     acc_q, acc_d, acc_s;
    logic [CNTWIDTH-1:0]    cnt_q, cnt_d, cnt_s;
    logic [2*DATAWIDTH-1:0] prod_q, prod_d, res;
    logic                   busy_q, busy_d, done_q, done_d, zero_q, zero_d, ovf_q, ovf_d, last;
`ifdef MULT_EARLY_EXIT_EN
    logic [DATAWIDTH-1:0]   rem_mask;
`endif

    mult_addshift_step #(.DATAWIDTH(DATAWIDTH)) u_step (
        .acc_i(acc_q), .p_i(p_q), .a_i(a_q), .acc_o(acc_s), .p_o(p_s)
    );

    always_comb begin
        cnt_s = cnt_q - CNTWIDTH'(1);
`ifdef MULT_EARLY_EXIT_EN
        // low cnt_s bits of P are still unconsumed multiplier bits; realign the product on exit
        rem_mask = ~({DATAWIDTH{1'b1}} << cnt_s);
        last     = (cnt_q == CNTWIDTH'(1)) || ((p_s & rem_mask) == '0);
        res      = {acc_s[DATAWIDTH-1:0], p_s} >> cnt_s;
`else
        last     = cnt_q == CNTWIDTH'(1);
        res      = {acc_s[DATAWIDTH-1:0], p_s};
`endif
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (sStart) begin
                state_d = LOAD;
                a_d     = sDataInA;
                p_d     = sDataInB;
                busy_d  = 1'b1;
            end
            LOAD: begin
                acc_d   = '0;
                cnt_d   = CNTWIDTH'(DATAWIDTH);
                state_d = CALC;
                busy_d  = 1'b1;
`ifdef MULT_EARLY_EXIT_EN
                if (p_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    prod_d  = '0;
                    zero_d  = 1'b1;
                    ovf_d   = 1'b0;
                end
`endif
            end
            CALC: begin
                acc_d  = acc_s;
                p_d    = p_s;
                cnt_d  = cnt_s;
                busy_d = 1'b1;
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    prod_d  = res;
                    zero_d  = res == '0;
                    ovf_d   = |res[2*DATAWIDTH-1:DATAWIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_System or negedge lowRst_System) begin
        if (!lowRst_System) begin
            state_q <= IDLE;
            a_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sProduct  = prod_q;
    assign sBusy     = busy_q;
    assign sDone     = done_q;
    assign sZero     = zero_q;
    assign sOverflow = ovf_q;
endmodule

// File: tb/tb_shiftadd_multiplier_system.sv
// tb_shiftadd_multiplier_system: directed scoreboard bench for the shift-add multiplier
module tb_shiftadd_multiplier_system;
    localparam int W = 8;
    typedef struct {
        logic [2*W-1:0] prod;
        logic           z;
        logic           o;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] sProduct;
    logic           sBusy, sDone, sZero, sOverflow;
    exp_t           sb[$];
    int             cyc, busy_cnt, n_assert, n_fail;
    logic [2*W-1:0] held;

    always #5 clk = ~clk;

    shiftadd_multiplier_system #(.DATAWIDTH(W)) dut (
        .Clk_System(clk), .lowRst_System(rst_n), .sStart(start),
        .sDataInA(a), .sDataInB(b), .sProduct(sProduct), .sBusy(sBusy),
        .sDone(sDone), .sZero(sZero), .sOverflow(sOverflow)
    );

    function automatic int lat(input logic [W-1:0] bb);
`ifdef MULT_EARLY_EXIT_EN
        int l = 2;
        for (int i = 0; i < W; i++) if (bb[i]) l = 3 + i;
        return l;
`else
        return W + 2;
`endif
    endfunction

    function automatic exp_t mk(input logic [W-1:0] aa, input logic [W-1:0] bb, input int c0);
        exp_t e;
        e.prod = {{W{1'b0}}, aa} * {{W{1'b0}}, bb};
        e.z    = e.prod == '0;
        e.o    = |e.prod[2*W-1:W];
        e.cyc  = c0 + lat(bb);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sBusy) busy_cnt++;
        if (sDone) begin
            if (sb.size() == 0) chk("spurious_done", 32'(sDone), 32'd0);
            else begin
                e = sb.pop_front();
                chk("product", 32'(sProduct), 32'(e.prod));
                chk("zero", 32'(sZero), 32'(e.z));
                chk("overflow", 32'(sOverflow), 32'(e.o));
                chk("done_cycle", cyc, e.cyc);
                held = e.prod;
            end
        end else chk("hold", 32'(sProduct), 32'(held));
    endtask

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        cyc = 0;
        busy_cnt = 0;
        sb.push_back(mk(aa, bb, 0));
        tick();
        @(negedge clk);
        start = 1'b0;
        while (sb.size() > 0 && cyc < 40) tick();
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
        end
        chk("busy_cycles", busy_cnt, lat(bb) - 1);
        tick();
        chk("done_pulse", 32'(sDone), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_product"}, 32'(sProduct), 32'd0);
        chk({tag, "_busy"}, 32'(sBusy), 32'd0);
        chk({tag, "_done"}, 32'(sDone), 32'd0);
        chk({tag, "_zero"}, 32'(sZero), 32'd0);
        chk({tag, "_overflow"}, 32'(sOverflow), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        held = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h57, 8'h02);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'h9C);
        run_op(8'h10, 8'h03);
        run_op(8'h5A, 8'h00);

        // start held high; operands change mid-CALC and feed the second accepted start
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        cyc = 0;
        sb.push_back(mk(8'h12, 8'h34, 0));
        while (cyc < 5) tick();
        @(negedge clk);
        a = 8'h21;
        b = 8'h43;
        sb.push_back(mk(8'h21, 8'h43, lat(8'h34) + 1));
        while (cyc < lat(8'h34) + 2) tick();
        @(negedge clk);
        start = 1'b0;
        while (sb.size() > 0 && cyc < 80) tick();
        if (sb.size() != 0) begin
            chk("timeout_b2b", sb.size(), 0);
            sb.delete();
        end
        repeat (3) tick();
        chk("no_third_start", 32'(sBusy), 32'd0);

        // asynchronous reset in the middle of CALC aborts without a done pulse
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        start = 1'b1;
        cyc = 0;
        tick();
        @(negedge clk);
        start = 1'b0;
        while (cyc < 5) tick();
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        held = '0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h0C, 8'h0B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
